// File: rtl/fetch_queue.sv
// Instruction fetch: owns the PC, issues imem req/ack reads, buffers returns in a DEPTH-entry FIFO.
// Define FETCH_BYPASS_EN to forward an acked word straight to out_* when the FIFO is empty.
module fetch_queue #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INSTR_W  = 16,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               stall,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [2:0]         opcode,
  output logic [3:0]         func
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    drain_pc_q, drain_pc_d;
  logic [PC_W-1:0]    pc_mem [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               fire, run_ack, push, pop, bypass;

  // A single request in flight at a time, so a non-full FIFO is enough to issue.
  always_comb begin
    imem_req = 1'b0;
    unique case (state_q)
      RUN:     imem_req = (count_q < FULL);
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = (state_q == DRAIN) ? drain_pc_q : fetch_pc_q;
  assign fire      = imem_req & imem_ack;
  assign run_ack   = (state_q == RUN) & fire;

`ifdef FETCH_BYPASS_EN
  assign bypass = (count_q == '0) & run_ack & ~redirect;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = (count_q != '0) & ~stall & ~redirect;
  assign push = run_ack & ~redirect & ~(bypass & ~stall);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drain_pc_d = drain_pc_q;
    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        // Redirect with the read still pending: keep the old address on the bus until it acks.
        if (redirect && imem_req && !imem_ack) begin
          state_d    = DRAIN;
          drain_pc_d = fetch_pc_q;
        end
      end
      DRAIN:   if (imem_ack) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (run_ack) begin
      fetch_pc_d = fetch_pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      drain_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drain_pc_q <= drain_pc_d;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr_q]    <= fetch_pc_q;
        instr_mem[wr_ptr_q] <= imem_rdata;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_comb begin
    out_valid = (count_q != '0);
    out_instr = instr_mem[rd_ptr_q];
    out_pc    = pc_mem[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
    if (bypass) begin
      out_valid = 1'b1;
      out_instr = imem_rdata;
      out_pc    = fetch_pc_q;
    end
`endif
  end

  assign opcode = out_instr[15:13];
  assign func   = out_instr[3:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner sequences and a
// randomized run checked against an in-order instruction-stream model.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [2:0]  opcode;
  logic [3:0]  func;

  int   checks = 0;
  int   errors = 0;
  int   lat = 0;
  int   waited = 0;
  logic ack_force = 1'b0;

  always #5 CLK = ~CLK;

  fetch_queue #(
    .PC_W    (16),
    .INSTR_W (16),
    .DEPTH   (2),
    .RESET_PC(16'h0000)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .opcode     (opcode),
    .func       (func)
  );

  // Memory contents: address 0 holds 16'hA00B.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return 16'hA00B + a * 16'd7;
  endfunction

  // Memory acks once the request has been held for lat cycles (lat 0 = same cycle).
  assign imem_ack   = ack_force | (imem_req & (waited >= lat));
  assign imem_rdata = ack_force ? 16'hDEAD : memf(imem_addr);

  always @(posedge CLK) begin
    if (!imem_req || imem_ack) waited <= 0;
    else waited <= waited + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},  32'd0);
    chk({tag, "_addr"},  {16'd0, imem_addr}, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_instr"}, {16'd0, out_instr}, 32'd0);
    chk({tag, "_pc"},    {16'd0, out_pc},    32'd0);
    chk({tag, "_op"},    {29'd0, opcode},    32'd0);
    chk({tag, "_func"},  {28'd0, func},      32'd0);
  endtask

  // Leaves the bench one time unit into the first cycle after reset release (IDLE cycle).
  task automatic do_reset();
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    ack_force   = 1'b0;
    reset       = 1'b0;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        ev;
    logic [15:0] epc;
    logic        ereq;
    logic [15:0] eaddr;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [15:0] rp,
                              input logic ev, input logic [15:0] epc,
                              input logic erq, input logic [15:0] ea);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp; v.ev = ev; v.epc = epc; v.ereq = erq; v.eaddr = ea;
    return v;
  endfunction

  vec_t        vecs[15];
  logic [15:0] exp_instr;
  logic [15:0] exp_pc;
  logic [15:0] acked[$];
  logic        found, got, prev_redirect, prev_hold;
  logic [15:0] prev_addr;
  int          delivered;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check_reset_vals("init");

    // Zero-wait memory, stall for 8 cycles, drain, then redirect coinciding with an ack.
    vecs[0]  = mk(1, 0, 16'h0,  0, 16'h0,  0, 16'h0);
    vecs[1]  = mk(1, 0, 16'h0,  0, 16'h0,  1, 16'h0);
    vecs[2]  = mk(1, 0, 16'h0,  1, 16'h0,  1, 16'h1);
    vecs[3]  = mk(1, 0, 16'h0,  1, 16'h0,  0, 16'h2);
    vecs[4]  = mk(1, 0, 16'h0,  1, 16'h0,  0, 16'h2);
    vecs[5]  = mk(1, 0, 16'h0,  1, 16'h0,  0, 16'h2);
    vecs[6]  = mk(1, 0, 16'h0,  1, 16'h0,  0, 16'h2);
    vecs[7]  = mk(1, 0, 16'h0,  1, 16'h0,  0, 16'h2);
    vecs[8]  = mk(0, 0, 16'h0,  1, 16'h0,  0, 16'h2);
    vecs[9]  = mk(0, 0, 16'h0,  1, 16'h1,  1, 16'h2);
    vecs[10] = mk(0, 0, 16'h0,  1, 16'h2,  1, 16'h3);
    vecs[11] = mk(0, 0, 16'h0,  1, 16'h3,  1, 16'h4);
    vecs[12] = mk(0, 1, 16'h40, 1, 16'h4,  1, 16'h5);
    vecs[13] = mk(0, 0, 16'h0,  0, 16'h0,  1, 16'h40);
    vecs[14] = mk(0, 0, 16'h0,  1, 16'h40, 1, 16'h41);

    lat = 0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      stall       = vecs[i].stall;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      @(negedge CLK);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].ereq});
      chk($sformatf("vec%0d_addr", i), {16'd0, imem_addr}, {16'd0, vecs[i].eaddr});
      if (vecs[i].ev) begin
        exp_instr = memf(vecs[i].epc);
        chk($sformatf("vec%0d_pc", i), {16'd0, out_pc}, {16'd0, vecs[i].epc});
        chk($sformatf("vec%0d_instr", i), {16'd0, out_instr}, {16'd0, exp_instr});
        chk($sformatf("vec%0d_opcode", i), {29'd0, opcode}, {29'd0, exp_instr[15:13]});
        chk($sformatf("vec%0d_func", i), {28'd0, func}, {28'd0, exp_instr[3:0]});
      end
      if (i == 2) begin
        chk("first_opcode", {29'd0, opcode}, 32'd5);
        chk("first_func", {28'd0, func}, 32'd11);
      end
      next_cycle();
    end
    redirect = 1'b0;

    // Redirect while the read of address 3 is pending on a 3-cycle memory.
    do_reset();
    lat = 3;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge CLK);
      if (imem_req && imem_addr == 16'd3) found = 1'b1;
    end
    chk("drain_reach_addr3", {31'd0, found}, 32'd1);
    next_cycle();
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge CLK);
    chk("drain_pre_ack", {31'd0, imem_ack}, 32'd0);
    next_cycle();
    redirect = 1'b0;
    @(negedge CLK);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    chk("drain_addr", {16'd0, imem_addr}, 32'd3);
    acked.delete();
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge CLK);
      if (imem_req && imem_ack) acked.push_back(imem_addr);
      if (out_valid) begin
        got = 1'b1;
        chk("drain_first_pc", {16'd0, out_pc}, 32'h40);
        chk("drain_first_instr", {16'd0, out_instr}, {16'd0, memf(16'h0040)});
      end
    end
    chk("drain_got_valid", {31'd0, got}, 32'd1);
    chk("drain_ack_count", acked.size(), 32'd2);
    if (acked.size() == 2) begin
      chk("drain_ack0_addr", {16'd0, acked[0]}, 32'd3);
      chk("drain_ack1_addr", {16'd0, acked[1]}, 32'h40);
    end

    // Redirect coinciding with an ack while stalled.
    do_reset();
    lat = 0;
    stall = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge CLK);
      if (imem_req && imem_ack) found = 1'b1;
    end
    chk("coinc_first_ack", {31'd0, found}, 32'd1);
    next_cycle();
    redirect = 1'b1; redirect_pc = 16'h0100;
    @(negedge CLK);
    chk("coinc_ack", {31'd0, imem_ack}, 32'd1);
    chk("coinc_valid_before", {31'd0, out_valid}, 32'd1);
    next_cycle();
    redirect = 1'b0;
    @(negedge CLK);
    chk("coinc_valid_after", {31'd0, out_valid}, 32'd0);
    chk("coinc_addr", {16'd0, imem_addr}, 32'h100);
    next_cycle();
    stall = 1'b0;
    @(negedge CLK);
    chk("coinc_next_valid", {31'd0, out_valid}, 32'd1);
    chk("coinc_next_pc", {16'd0, out_pc}, 32'h100);
    chk("coinc_next_instr", {16'd0, out_instr}, {16'd0, memf(16'h0100)});

    // PC wrap from all-ones to zero.
    do_reset();
    lat = 0;
    next_cycle();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    next_cycle();
    redirect = 1'b0;
    @(negedge CLK);
    chk("wrap_valid0", {31'd0, out_valid}, 32'd0);
    chk("wrap_addr_ffff", {16'd0, imem_addr}, 32'hFFFF);
    next_cycle();
    @(negedge CLK);
    chk("wrap_pc_ffff", {16'd0, out_pc}, 32'hFFFF);
    chk("wrap_addr_0", {16'd0, imem_addr}, 32'h0);
    next_cycle();
    @(negedge CLK);
    chk("wrap_valid1", {31'd0, out_valid}, 32'd1);
    chk("wrap_pc_0", {16'd0, out_pc}, 32'h0);

    // Reset pulsed while draining a non-zero address, with a stray ack across release.
    do_reset();
    lat = 0;
    next_cycle();
    redirect = 1'b1; redirect_pc = 16'h0300;
    next_cycle();
    redirect = 1'b0; lat = 5;
    next_cycle();
    redirect = 1'b1; redirect_pc = 16'h0200;
    next_cycle();
    redirect = 1'b0;
    @(negedge CLK);
    chk("mid_drain_req", {31'd0, imem_req}, 32'd1);
    chk("mid_drain_addr", {16'd0, imem_addr}, 32'h300);
    #2 reset = 1'b0; ack_force = 1'b1;
    #1 check_reset_vals("mid_drain_rst");
    next_cycle();
    reset = 1'b1;
    next_cycle();
    ack_force = 1'b0; lat = 0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge CLK);
      if (out_valid) begin
        got = 1'b1;
        chk("restart_pc", {16'd0, out_pc}, 32'h0);
        chk("restart_instr", {16'd0, out_instr}, 32'hA00B);
      end
    end
    chk("restart_got_valid", {31'd0, got}, 32'd1);

    // Randomized run against the in-order stream model.
    do_reset();
    lat = 1;
    exp_pc = 16'h0000;
    prev_redirect = 1'b0;
    prev_hold = 1'b0;
    prev_addr = 16'h0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) next_cycle();
      stall    = ($urandom_range(99) < 30);
      redirect = ($urandom_range(99) < 4);
      if ($urandom_range(3) == 0) redirect_pc = 16'hFFFD + 16'($urandom_range(2));
      else redirect_pc = 16'($urandom);
      if ($urandom_range(49) == 0) lat = $urandom_range(3);
      @(negedge CLK);
      if (prev_redirect) chk($sformatf("rnd%0d_valid_after_redirect", c), {31'd0, out_valid}, 32'd0);
      if (prev_hold) begin
        chk($sformatf("rnd%0d_req_held", c), {31'd0, imem_req}, 32'd1);
        chk($sformatf("rnd%0d_addr_stable", c), {16'd0, imem_addr}, {16'd0, prev_addr});
      end
      if (out_valid) begin
        chk($sformatf("rnd%0d_pc", c), {16'd0, out_pc}, {16'd0, exp_pc});
        chk($sformatf("rnd%0d_instr", c), {16'd0, out_instr}, {16'd0, memf(exp_pc)});
        if (!stall && !redirect) begin
          exp_pc = exp_pc + 16'd1;
          delivered++;
        end
      end
      if (redirect) exp_pc = redirect_pc;
      prev_redirect = redirect;
      prev_hold     = imem_req && !imem_ack;
      prev_addr     = imem_addr;
    end
    chk("rnd_liveness", {31'd0, (delivered > 200)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
